// File: rtl/led_bar_pkg.sv
// Shared types and constants for the LED bar-graph controller.
//   state_t     : controller FSM encoding
//   action_t    : bar update selected for the current cycle
//   BTN_PRESSED : pad level that means "button pressed" (buttons are active-low)
package led_bar_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_UP   = 2'd1,
        HOLD_DN   = 2'd2,
        HOLD_BOTH = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_FILL  = 2'd1,
        ACT_DRAIN = 2'd2,
        ACT_CLEAR = 2'd3
    } action_t;

    localparam logic BTN_PRESSED = 1'b0;

endpackage

// File: rtl/led_bar_if.sv
// Board-side bundle between push-buttons and the LED bank.
//   pb1   : raw active-low drain button
//   pb2   : raw active-low fill button
//   leds  : thermometer bar pattern
//   full  : all LEDs lit
//   empty : no LED lit
//   step  : one-cycle pulse per bar action
// master = board/testbench side, slave = controller side.
interface led_bar_if #(
    parameter int unsigned WIDTH = 8
);
    logic             pb1;
    logic             pb2;
    logic [WIDTH-1:0] leds;
    logic             full;
    logic             empty;
    logic             step;

    modport master (output pb1, output pb2,
                    input  leds, input full, input empty, input step);
    modport slave  (input  pb1, input pb2,
                    output leds, output full, output empty, output step);
endinterface

// File: rtl/led_bar_btn_debounce.sv
// Two-flop synchroniser plus debouncer for one active-low push-button.
//   clk, rst_n : clock and asynchronous active-low reset
//   raw_n      : raw pad level, asynchronous to clk
//   pressed    : registered debounced state, 1 = pressed
// The debounced state flips once the synchronised level has disagreed with it
// for DEBOUNCE_CYCLES consecutive edges; any agreeing sample restarts the count.
module btn_debounce
    import led_bar_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic pressed
);

    localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             pressed_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchroniser chain, stability counter and debounced state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            pressed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q <= raw_n;
            sync2_q <= sync1_q;
            if ((sync2_q == BTN_PRESSED) != pressed_q) begin
                if (cnt_q == CNT_LAST) begin
                    pressed_q <= ~pressed_q;
                    cnt_q     <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign pressed = pressed_q;

endmodule

// File: rtl/led_bar_ctrl.sv
// Push-button LED bar-graph controller.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : led_bar_if.slave (pb1 drain, pb2 fill, leds/full/empty/step)
// Each debounced press fills or drains the bar by one LED; pressing both in the
// same cycle clears it. A held button does not act again until both buttons
// have been released. Define LED_BAR_AUTOREPEAT_EN to repeat a held fill/drain
// after REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
module led_bar_ctrl
    import led_bar_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_PERIOD   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    led_bar_if.slave   bus
);

    if (WIDTH < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("led_bar_ctrl: illegal parameter value");
    end

    logic             fill_p;
    logic             drain_p;
    state_t           state_q, state_d;
    action_t          act;
    logic [WIDTH-1:0] leds_q, leds_d;
    logic             full_q, empty_q, step_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_drain (
        .clk(clk), .rst_n(rst_n), .raw_n(bus.pb1), .pressed(drain_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fill (
        .clk(clk), .rst_n(rst_n), .raw_n(bus.pb2), .pressed(fill_p)
    );

`ifdef LED_BAR_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [RPT_W-1:0] rpt_limit;
    logic             rpt_started_q, rpt_started_d;
    logic             rpt_stop_q, rpt_stop_d;
    logic             hold_own, hold_other;

    // First repeat waits the long delay, later ones the short period.
    assign rpt_limit = rpt_started_q ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);

    // Repeat counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q     <= '0;
            rpt_started_q <= 1'b0;
            rpt_stop_q    <= 1'b0;
        end else begin
            rpt_cnt_q     <= rpt_cnt_d;
            rpt_started_q <= rpt_started_d;
            rpt_stop_q    <= rpt_stop_d;
        end
    end
`endif

    // FSM state, bar register and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            leds_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            leds_q  <= leds_d;
            full_q  <= &leds_d;
            empty_q <= ~|leds_d;
            step_q  <= (act != ACT_NONE);
        end
    end

    // Next state, action select and bar update.
    always_comb begin
        state_d = state_q;
        act     = ACT_NONE;
`ifdef LED_BAR_AUTOREPEAT_EN
        rpt_cnt_d     = rpt_cnt_q;
        rpt_started_d = rpt_started_q;
        rpt_stop_d    = rpt_stop_q;
        hold_own      = (state_q == HOLD_UP) ? fill_p  : drain_p;
        hold_other    = (state_q == HOLD_UP) ? drain_p : fill_p;
`endif
        case (state_q)
            IDLE: begin
                if (fill_p && drain_p) begin
                    act     = ACT_CLEAR;
                    state_d = HOLD_BOTH;
                end else if (fill_p) begin
                    act     = ACT_FILL;
                    state_d = HOLD_UP;
                end else if (drain_p) begin
                    act     = ACT_DRAIN;
                    state_d = HOLD_DN;
                end
`ifdef LED_BAR_AUTOREPEAT_EN
                rpt_cnt_d     = '0;
                rpt_started_d = 1'b0;
                rpt_stop_d    = 1'b0;
`endif
            end
            HOLD_UP, HOLD_DN: begin
                if (!fill_p && !drain_p) begin
                    state_d = IDLE;
                end
`ifdef LED_BAR_AUTOREPEAT_EN
                // A second button kills repeating for the rest of this hold.
                else if (hold_other || !hold_own) begin
                    rpt_stop_d = 1'b1;
                    rpt_cnt_d  = '0;
                end else if (!rpt_stop_q) begin
                    if (rpt_cnt_q == rpt_limit) begin
                        act           = (state_q == HOLD_UP) ? ACT_FILL : ACT_DRAIN;
                        rpt_cnt_d     = '0;
                        rpt_started_d = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end
`endif
            end
            HOLD_BOTH: begin
                if (!fill_p && !drain_p) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        case (act)
            ACT_FILL:  leds_d = {leds_q[WIDTH-2:0], 1'b1};
            ACT_DRAIN: leds_d = {1'b0, leds_q[WIDTH-1:1]};
            ACT_CLEAR: leds_d = '0;
            default:   leds_d = leds_q;
        endcase
    end

    assign bus.leds  = leds_q;
    assign bus.full  = full_q;
    assign bus.empty = empty_q;
    assign bus.step  = step_q;

endmodule

// File: tb/tb_led_bar_ctrl.sv
// Bench for led_bar_ctrl: directed scenarios followed by random button activity,
// every cycle checked against a count-based reference model of the bar.
module tb_led_bar_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned DB = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_bar_if #(.WIDTH(W)) bus ();

    led_bar_ctrl #(
        .WIDTH(W), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Reference model: bar held as a count of lit LEDs.
    int  m_n;
    bit  m_busy, m_rpt_on, m_rpt_fill, m_step;
    int  m_cyc, m_next_fire;
    bit  m_s1 [2];
    bit  m_s2 [2];
    bit  m_dbp[2];
    bit  hq0[$];
    bit  hq1[$];

    function automatic logic [W-1:0] exp_leds();
        logic [W-1:0] v = '0;
        for (int i = 0; i < m_n; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic bit win_toggle(input bit q[$], input bit lvl_raw);
        if (q.size() != DB) return 1'b0;
        foreach (q[i]) if (q[i] == lvl_raw) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_n = 0; m_busy = 0; m_rpt_on = 0; m_rpt_fill = 0; m_step = 0;
        m_next_fire = 0;
        for (int b = 0; b < 2; b++) begin
            m_s1[b] = 1; m_s2[b] = 1; m_dbp[b] = 0;
        end
        hq0.delete(); hq1.delete();
    endtask

    task automatic apply(input int kind);
        if (kind == 1 && m_n < int'(W)) m_n++;
        if (kind == 2 && m_n > 0) m_n--;
        if (kind == 3) m_n = 0;
        m_step = 1;
    endtask

    task automatic start_rpt(input bit f);
`ifdef LED_BAR_AUTOREPEAT_EN
        m_rpt_on = 1; m_rpt_fill = f; m_next_fire = m_cyc + RD;
`else
        m_rpt_on = 0; m_rpt_fill = f;
`endif
    endtask

    task automatic model_edge();
        bit pf, pd;
        pf = m_dbp[1]; pd = m_dbp[0];
        m_cyc++;
        m_step = 0;
        if (!m_busy) begin
            if (pf && pd)   begin apply(3); m_busy = 1; m_rpt_on = 0; end
            else if (pf)    begin apply(1); m_busy = 1; start_rpt(1); end
            else if (pd)    begin apply(2); m_busy = 1; start_rpt(0); end
        end else if (!pf && !pd) begin
            m_busy = 0; m_rpt_on = 0;
        end else if (m_rpt_on) begin
            if (m_rpt_fill ? (pd || !pf) : (pf || !pd)) m_rpt_on = 0;
            else if (m_cyc == m_next_fire) begin
                apply(m_rpt_fill ? 1 : 2);
                m_next_fire = m_cyc + RP;
            end
        end
        hq0.push_back(m_s2[0]); if (hq0.size() > DB) void'(hq0.pop_front());
        hq1.push_back(m_s2[1]); if (hq1.size() > DB) void'(hq1.pop_front());
        if (win_toggle(hq0, !m_dbp[0])) m_dbp[0] = !m_dbp[0];
        if (win_toggle(hq1, !m_dbp[1])) m_dbp[1] = !m_dbp[1];
        m_s2[0] = m_s1[0]; m_s1[0] = bus.pb1;
        m_s2[1] = m_s1[1]; m_s1[1] = bus.pb2;
    endtask

    task automatic chk_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin n_fail++; $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, m_cyc, obs, exp); end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin n_fail++; $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, m_cyc, obs, exp); end
    endtask

    task automatic check_outputs(input string tag);
        chk_vec({tag, "_leds"}, bus.leds, exp_leds());
        chk_int({tag, "_full"}, int'(bus.full), int'(m_n == int'(W)));
        chk_int({tag, "_empty"}, int'(bus.empty), int'(m_n == 0));
        chk_int({tag, "_step"}, int'(bus.step), int'(m_step));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge(); else model_reset();
        #1;
        check_outputs("cycle");
    endtask

    // Hold one button (0 = pb1 drain, 1 = pb2 fill, 2 = both) then release; count step pulses.
    task automatic press(input int which, input int hold, input int gap, output int steps);
        steps = 0;
        if (which != 1) bus.pb1 = 1'b0;
        if (which != 0) bus.pb2 = 1'b0;
        repeat (hold) begin tick(); steps += int'(bus.step); end
        bus.pb1 = 1'b1; bus.pb2 = 1'b1;
        repeat (gap) begin tick(); steps += int'(bus.step); end
    endtask

    initial begin
        int s, tot, rem1, rem2;
        m_cyc = 0;
        model_reset();
        bus.pb1 = 1'b1; bus.pb2 = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();
        chk_vec("reset_leds", bus.leds, 8'h00);
        chk_int("reset_empty", int'(bus.empty), 1);
        chk_int("reset_full", int'(bus.full), 0);
        chk_int("reset_step", int'(bus.step), 0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Clean fill: bar moves 3 + DEBOUNCE_CYCLES edges after the pad falls.
        bus.pb2 = 1'b0;
        repeat (6) tick();
        chk_vec("fill_before_latency", bus.leds, 8'h00);
        tick();
        chk_vec("fill_latency7", bus.leds, 8'h01);
        chk_int("fill_step", int'(bus.step), 1);
        tick();
        chk_int("fill_step_one_cycle", int'(bus.step), 0);
        bus.pb2 = 1'b1;
        repeat (12) tick();
        press(1, 8, 12, s);
        chk_vec("second_fill", bus.leds, 8'h03);
        chk_int("second_fill_steps", s, 1);

        // Bounce rejection.
        s = 0;
        for (int i = 0; i < 15; i++) begin
            bus.pb2 = ~bus.pb2;
            repeat (2) begin tick(); s += int'(bus.step); end
        end
        bus.pb2 = 1'b1;
        repeat (12) begin tick(); s += int'(bus.step); end
        chk_int("bounce_no_step", s, 0);
        chk_vec("bounce_leds", bus.leds, 8'h03);
        press(1, 8, 12, s);
        chk_int("post_bounce_steps", s, 1);
        chk_vec("post_bounce_leds", bus.leds, 8'h07);

        // Saturation in both directions.
        repeat (3) press(0, 8, 12, s);
        chk_vec("drain_to_zero", bus.leds, 8'h00);
        for (int i = 1; i <= 9; i++) begin
            press(1, 8, 12, s);
            if (i == 8) begin
                chk_vec("sat_fill8_leds", bus.leds, 8'hFF);
                chk_int("sat_fill8_full", int'(bus.full), 1);
            end
            if (i == 9) begin
                chk_int("sat_fill9_step", s, 1);
                chk_vec("sat_fill9_leds", bus.leds, 8'hFF);
            end
        end
        tot = 0;
        for (int i = 1; i <= 9; i++) begin press(0, 8, 12, s); tot += s; end
        chk_int("sat_drain_steps", tot, 9);
        chk_vec("sat_drain_leds", bus.leds, 8'h00);
        chk_int("sat_drain_empty", int'(bus.empty), 1);

        // Chord clear, then partial release gives nothing more.
        repeat (4) press(1, 8, 12, s);
        chk_vec("chord_pre", bus.leds, 8'h0F);
        s = 0;
        bus.pb1 = 1'b0; bus.pb2 = 1'b0;
        repeat (12) begin tick(); s += int'(bus.step); end
        bus.pb1 = 1'b1;
        repeat (12) begin tick(); s += int'(bus.step); end
        bus.pb2 = 1'b1;
        repeat (12) begin tick(); s += int'(bus.step); end
        chk_int("chord_steps", s, 1);
        chk_vec("chord_leds", bus.leds, 8'h00);

        // Long hold: repeats only when the feature is built in.
        press(1, 30, 12, s);
`ifdef LED_BAR_AUTOREPEAT_EN
        chk_int("hold_steps", s, 6);
        chk_vec("hold_leds", bus.leds, 8'h3F);
`else
        chk_int("hold_steps", s, 1);
        chk_vec("hold_leds", bus.leds, 8'h01);
`endif

        // Reset mid-hold, button still held afterwards.
        bus.pb2 = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (15) tick();
        bus.pb2 = 1'b1;
        repeat (12) tick();

        // Random activity with occasional resets.
        rem1 = 1; rem2 = 1;
        for (int c = 0; c < 2500; c++) begin
            if (--rem1 == 0) begin
                bus.pb1 = $urandom_range(0, 2) != 0;
                rem1 = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
            end
            if (--rem2 == 0) begin
                bus.pb2 = $urandom_range(0, 1) != 0;
                rem2 = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
            end
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_outputs("rand_async_reset");
                repeat (2) tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/led_bar_ctrl.md
# led_bar_ctrl

Parametrised push-button LED bar-graph controller: two active-low push-buttons fill or drain a WIDTH-bit thermometer bar, one step per press. Compared with the first-generation button/LED FSM, this block adds:
- input synchronisation and debounce;
- a clear-on-chord action;
- full/empty flags and a step strobe;
- optional hold-to-auto-repeat.

It sits directly between board push-buttons and the LED bank, in the top-level board wrapper.

## Interface
Parameters:
- WIDTH, 8, number of LEDs (≥2)
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a button level change (≥1)
- REPEAT_DELAY, 64, held cycles before the first auto-repeat step (≥1)
- REPEAT_PERIOD, 16, cycles between subsequent auto-repeat steps (≥1)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- pb1  in  1  raw active-low "drain" button, asynchronous to clk
- pb2  in  1  raw active-low "fill" button, asynchronous to clk
- leds  out  WIDTH  bar pattern, always thermometer-coded from bit 0
- full  out  1  leds all ones
- empty  out  1  leds all zeros
- step  out  1  one-cycle pulse on every cycle leds is written by an action

## Operation
Reset values (asynchronous, while rst_n=0):
- leds=0, full=0, empty=1, step=0.
- FSM=IDLE; repeat counter=0.
- Synchroniser flops=1; debounced levels=released.

Input conditioning:
- Each button passes a 2-flop synchroniser, then a debouncer.
- The debounced level toggles on the edge where the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive edges.
- Any bounce back to the current level restarts the count.
- Internally, press = debounced low.

Actions:
- fill: leds ← {leds[WIDTH-2:0],1}; saturates at all ones.
- drain: leds ← {0,leds[WIDTH-1:1]}; saturates at zero.
- clear: leds ← 0.
- step pulses on every fill, drain or clear, including saturated ones (leds unchanged).

FSM states:
- IDLE:
  - fill pressed alone → fill, go HOLD_UP.
  - drain pressed alone → drain, go HOLD_DN.
  - both pressed in the same cycle → clear, go HOLD_BOTH.
  - neither pressed → stay.
- HOLD_UP / HOLD_DN: go IDLE when both buttons are released. A second button pressed while holding is ignored, with no clear.
- HOLD_BOTH: go IDLE when both buttons are released. No actions.
- Any button still held on return to IDLE is not re-triggered; a new press needs a debounced release first.

Boundary rules:
- full = &leds; empty = ~|leds.
- Both flags are registered together with leds.
- Reset mid-hold aborts immediately. After reset, a still-held button acts only once its debounced press is newly seen.

## Timing
- A pad change held stable reaches the debounced level after 2 + DEBOUNCE_CYCLES edges.
- leds, full, empty and step update on the following edge.
- Total latency from pad change to leds update is 3 + DEBOUNCE_CYCLES cycles.
- step is high for exactly one cycle per action. Maximum step rate is one per REPEAT_PERIOD cycles during auto-repeat.

## Configuration
- LED_BAR_AUTOREPEAT_EN defined:
  - In HOLD_UP/HOLD_DN, a counter runs while the button stays pressed.
  - A repeat action of the same kind fires REPEAT_DELAY cycles after the initial action, then every REPEAT_PERIOD cycles.
  - Releasing the button, or pressing the second button, stops and zeroes the counter; repeats do not resume.
- LED_BAR_AUTOREPEAT_EN undefined:
  - Exactly one action per press.
  - No repeat counter is synthesised; REPEAT_* parameters are unused.

## Structure
- Shared package led_bar_pkg holds:
  - the FSM state encoding (IDLE, HOLD_UP, HOLD_DN, HOLD_BOTH, 2-bit);
  - the button-pressed polarity constant.
- Sub-module btn_debounce: one instance per button, containing the 2-flop synchroniser and the DEBOUNCE_CYCLES counter.
  - Ports: clk, rst_n, raw_n, pressed.
- The top level holds the FSM, the bar register, the flags and the repeat counter.

## Test plan
- Reset then idle: rst_n low mid-operation → leds=0, empty=1, full=0, step=0 immediately; all hold after release.
- Clean fill: WIDTH=8, DEBOUNCE_CYCLES=4; pb2 low for 20 cycles, then high → leds=8'h01 exactly 7 cycles after the fall; one step pulse; a second press → 8'h03.
- Bounce rejection: pb2 toggling every 2 cycles for 30 cycles, then high → no step and leds unchanged; then pb2 stable low → exactly one fill.
- Saturation: fill 9 times from 0 → leds=8'hFF and full=1 after the 8th press; the 9th press gives a step pulse with leds unchanged. Drain 9 times → 8'h00 and empty=1.
- Chord clear: leds=8'h0F; pb1 and pb2 fall on the same cycle → leds=0 with one step; holding both, then releasing pb1 only, gives no further action.
- Auto-repeat (macro defined, REPEAT_DELAY=10, REPEAT_PERIOD=4): pb2 held for 30 cycles after the first action → further fills at +10, +14, +18, +22, +26 cycles. Without the macro → exactly one fill.
